// File: rtl/gbfwei_rd_arb.sv
// gbfwei_rd_arb: round-robin arbiter sharing the single GBFWEI weight read port among
// NUM_REQ weight distributors. One requester owns the port for a burst of up to MAX_BURST
// reads. Returning data is tagged through an id pipe so each read's valid strobe reaches
// its issuer, even after ownership has moved on.
// Optional build macro GBFWEI_ARB_PERF_EN adds the registered ArbStallCnt output.
module gbfwei_rd_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned PORT_WIDTH = 96,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          CTRLACT_FnhFrm,
    input  logic [NUM_REQ-1:0]            Req_Rqst,
    input  logic [NUM_REQ-1:0]            Req_EnRd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] Req_AddrRd,
    output logic [NUM_REQ-1:0]            Req_BusyRd,
    output logic [NUM_REQ-1:0]            Req_DatVal,
    output logic [PORT_WIDTH-1:0]         Req_DatRd,
    output logic                          GBFWEI_EnRd,
    output logic [ADDR_WIDTH-1:0]         GBFWEI_AddrRd,
    input  logic                          GBFWEI_BusyRd,
`ifdef GBFWEI_ARB_PERF_EN
    output logic [31:0]                   ArbStallCnt,
`endif
    input  logic [PORT_WIDTH-1:0]         GBFWEI_DatRd
);

    localparam int unsigned     IdW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned     CntW     = $clog2(MAX_BURST) + 1;
    localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);
    localparam logic [IdW-1:0]  LastId   = IdW'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StOwn, StRelease} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  owner_q, owner_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] burst_q, burst_d;
    // Remembers that the release was caused by a flush, so RELEASE restarts at requester 0
    logic            flush_pend_q, flush_pend_d;

    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [IdW-1:0]        pipe_id_q [RD_LATENCY];

    logic           own_act, rd_acc, burst_hit, pick_vld;
    logic [IdW-1:0] pick, owner_nxt;
    int             idx;

    // Circular first-set search over Req_Rqst starting at the round-robin pointer
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (!pick_vld && Req_Rqst[idx[IdW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[IdW-1:0];
            end
        end
    end

    assign owner_nxt = (owner_q == LastId) ? '0 : owner_q + 1'b1;

    // Grant, read forwarding and burst-limit detection; Req_BusyRd never looks at Req_EnRd
    always_comb begin
        own_act    = (state_q == StOwn);
        Req_BusyRd = '1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            Req_BusyRd[i] = !(own_act && (owner_q == IdW'(i))) || GBFWEI_BusyRd;
        end
        rd_acc        = own_act && Req_EnRd[owner_q] && !GBFWEI_BusyRd && !CTRLACT_FnhFrm;
        burst_hit     = rd_acc && ((burst_q + 1'b1) == BurstMax);
        GBFWEI_EnRd   = rd_acc;
        GBFWEI_AddrRd = own_act ? Req_AddrRd[owner_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    end

    // Decode the pipe tail into the per-requester valid strobe
    always_comb begin
        Req_DatVal = '0;
        if (pipe_vld_q[RD_LATENCY-1]) begin
            Req_DatVal[pipe_id_q[RD_LATENCY-1]] = 1'b1;
        end
    end

    assign Req_DatRd = GBFWEI_DatRd;

    // Ownership FSM next-state: arbitrate in IDLE, hold in OWN, one-cycle bubble in RELEASE
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        burst_d      = burst_q;
        flush_pend_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (CTRLACT_FnhFrm) begin
                    rr_ptr_d = '0;
                end else if (pick_vld) begin
                    owner_d = pick;
                    burst_d = '0;
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (rd_acc && (burst_q != BurstMax)) begin
                    burst_d = burst_q + 1'b1;
                end
                if (CTRLACT_FnhFrm) begin
                    state_d      = StRelease;
                    rr_ptr_d     = '0;
                    flush_pend_d = 1'b1;
                end else if (!Req_Rqst[owner_q] || burst_hit) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                state_d  = StIdle;
                rr_ptr_d = (CTRLACT_FnhFrm || flush_pend_q) ? '0 : owner_nxt;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            burst_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_q      <= burst_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Return-id pipe: one stage per cycle of GBFWEI read latency, emptied by a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < int'(RD_LATENCY); k++) begin
                pipe_id_q[k] <= '0;
            end
        end else if (CTRLACT_FnhFrm) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= rd_acc;
            pipe_id_q[0]  <= owner_q;
            for (int k = 1; k < int'(RD_LATENCY); k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_id_q[k]  <= pipe_id_q[k-1];
            end
        end
    end

`ifdef GBFWEI_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic        stall_any;

    assign stall_any   = |(Req_Rqst & Req_BusyRd);
    assign ArbStallCnt = stall_cnt_q;

    // Saturating count of cycles where some requester wants the port but is held off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (CTRLACT_FnhFrm) begin
            stall_cnt_q <= '0;
        end else if (stall_any && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gbfwei_rd_arb.sv
// tb_gbfwei_rd_arb: three arbiters (read latency 1, 2, 3) share one stimulus stream.
// A cycle-level reference model predicts every output; directed scenarios add literal checks.
module tb_gbfwei_rd_arb;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int PW = 96;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fl;
    logic [N-1:0]    rq, en;
    logic [N*AW-1:0] addr_flat;
    logic            gb;
    logic [PW-1:0]   gdat;

    logic [N-1:0]  o_busy  [3];
    logic [N-1:0]  o_dv    [3];
    logic [PW-1:0] o_drd   [3];
    logic          o_en    [3];
    logic [AW-1:0] o_gaddr [3];
    logic [31:0]   o_stall [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gbfwei_rd_arb #(
            .NUM_REQ   (N),
            .ADDR_WIDTH(AW),
            .PORT_WIDTH(PW),
            .RD_LATENCY(g + 1),
            .MAX_BURST (MB)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .CTRLACT_FnhFrm(fl),
            .Req_Rqst      (rq),
            .Req_EnRd      (en),
            .Req_AddrRd    (addr_flat),
            .Req_BusyRd    (o_busy[g]),
            .Req_DatVal    (o_dv[g]),
            .Req_DatRd     (o_drd[g]),
            .GBFWEI_EnRd   (o_en[g]),
            .GBFWEI_AddrRd (o_gaddr[g]),
            .GBFWEI_BusyRd (gb),
`ifdef GBFWEI_ARB_PERF_EN
            .ArbStallCnt   (o_stall[g]),
`endif
            .GBFWEI_DatRd  (gdat)
        );
`ifndef GBFWEI_ARB_PERF_EN
        assign o_stall[g] = 32'd0;
`endif
    end

    // Reference model state: phase 0=idle 1=own 2=release
    typedef struct {
        int       c0;
        int       id;
        bit [2:0] alive;
    } rec_t;

    int          ph, own, rr, cnt, cyc;
    bit          flp;
    logic [31:0] stall;
    rec_t        hist[$];

    int n_chk = 0;
    int n_pass = 0;

    // Observation logs taken from the latency-1 instance
    int en_own[$];
    int en_cyc[$];
    int dv_cnt [3][N];

    task automatic check(string nm, int g, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s L%0d cyc=%0d got=%0h want=%0h", nm, g + 1, cyc, act, exp);
    endtask

    function automatic int owner_of(logic [N-1:0] b);
        for (int i = 0; i < N; i++) if (!b[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        ph = 0; own = 0; rr = 0; cnt = 0; flp = 0; stall = 32'd0;
        hist.delete();
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic compare();
        logic [N-1:0]  eb, ed;
        logic          ee;
        logic [AW-1:0] ea;
        for (int i = 0; i < N; i++) eb[i] = !(ph == 1 && own == i) || gb;
        ee = (ph == 1) && en[own] && !gb && !fl;
        ea = (ph == 1) ? addr_flat[own*AW +: AW] : '0;
        for (int g = 0; g < 3; g++) begin
            ed = '0;
            foreach (hist[k]) if (hist[k].c0 == cyc - (g + 1) && hist[k].alive[g]) ed[hist[k].id] = 1'b1;
            check("busy", g, 128'(o_busy[g]), 128'(eb));
            check("gbf_en", g, 128'(o_en[g]), 128'(ee));
            check("gbf_addr", g, 128'(o_gaddr[g]), 128'(ea));
            check("dat_val", g, 128'(o_dv[g]), 128'(ed));
            check("dat_rd", g, 128'(o_drd[g]), 128'(gdat));
`ifdef GBFWEI_ARB_PERF_EN
            check("stall_cnt", g, 128'(o_stall[g]), 128'(stall));
`endif
            for (int i = 0; i < N; i++) if (o_dv[g][i]) dv_cnt[g][i]++;
        end
        if (o_en[0]) begin
            en_own.push_back(owner_of(o_busy[0]));
            en_cyc.push_back(cyc);
        end
    endtask

    // Advance the model across one rising edge using this cycle's inputs
    task automatic model_step();
        logic [N-1:0] bv;
        bit   acc;
        int   pk, ix;
        rec_t r;
        if (rst_n) begin
            acc = (ph == 1) && en[own] && !gb && !fl;
            for (int i = 0; i < N; i++) bv[i] = !(ph == 1 && own == i) || gb;
            if (acc) begin
                r.c0 = cyc; r.id = own; r.alive = 3'b111;
                hist.push_back(r);
            end
            if (fl) begin
                foreach (hist[k]) begin
                    r = hist[k];
                    for (int l = 1; l <= 3; l++) if (r.c0 + l > cyc) r.alive[l-1] = 1'b0;
                    hist[k] = r;
                end
                stall = 32'd0;
            end else if (|(rq & bv) && stall != 32'hFFFF_FFFF) begin
                stall = stall + 32'd1;
            end
            case (ph)
                0: begin
                    if (fl) rr = 0;
                    else if (rq != 0) begin
                        pk = -1;
                        for (int k = 0; k < N; k++) begin
                            ix = (rr + k) % N;
                            if (pk < 0 && rq[ix]) pk = ix;
                        end
                        own = pk; cnt = 0; ph = 1;
                    end
                end
                1: begin
                    if (acc && cnt < MB) cnt = cnt + 1;
                    if (fl) begin ph = 2; rr = 0; flp = 1; end
                    else if (!rq[own] || (acc && cnt == MB)) ph = 2;
                end
                default: begin
                    ph = 0;
                    rr = (fl || flp) ? 0 : (own + 1) % N;
                    flp = 0;
                end
            endcase
        end
        while (hist.size() > 0 && hist[0].c0 < cyc - 4) void'(hist.pop_front());
        cyc++;
    endtask

    task automatic neg(); @(negedge clk); compare(); endtask
    task automatic pos(); @(posedge clk); model_step(); #1; endtask
    task automatic step(); neg(); pos(); endtask
    task automatic set_addr(int i, int a); addr_flat[i*AW +: AW] = AW'(a); endtask

    initial begin
        int base, s_a, s_b, s_c;
        int order[5];
        order = '{0, 1, 2, 3, 0};
        cyc = 0;
        rst_n = 1'b0; fl = 1'b0; rq = '0; en = '0; addr_flat = '0; gb = 1'b0; gdat = '0;
        for (int g = 0; g < 3; g++) for (int i = 0; i < N; i++) dv_cnt[g][i] = 0;
        model_reset();
        neg();
        check("rst_busy", 0, 128'(o_busy[0]), 128'hF);
        check("rst_en", 0, 128'(o_en[0]), 128'h0);
        check("rst_addr", 0, 128'(o_gaddr[0]), 128'h0);
        pos(); step(); step();
        rst_n = 1'b1;

        // Single requester 2, three reads, then drop; next grant must start at requester 3
        rq = 4'b0100;
        neg(); check("s1_idle_busy", 0, 128'(o_busy[0]), 128'hF); pos();
        en = 4'b0100; set_addr(2, 'h010); s_a = dv_cnt[0][2]; s_b = dv_cnt[2][2];
        neg();
        check("s1_grant_busy", 0, 128'(o_busy[0]), 128'b1011);
        check("s1_en", 0, 128'(o_en[0]), 128'h1);
        check("s1_addr010", 0, 128'(o_gaddr[0]), 128'h010);
        pos();
        set_addr(2, 'h011);
        neg();
        check("s1_addr011", 0, 128'(o_gaddr[0]), 128'h011);
        check("s1_dv_lat1", 0, 128'(o_dv[0]), 128'b0100);
        pos();
        set_addr(2, 'h012);
        neg(); check("s1_addr012", 0, 128'(o_gaddr[0]), 128'h012); pos();
        rq = '0; en = '0;
        neg(); check("s1_drop_en", 0, 128'(o_en[0]), 128'h0); pos();
        rq = 4'b1001;
        neg(); check("s1_release_busy", 0, 128'(o_busy[0]), 128'hF); pos();
        step();
        neg(); check("s1_rrptr3", 0, 128'(o_busy[0]), 128'b0111); pos();
        check("s1_dv2_lat1", 0, 128'(dv_cnt[0][2] - s_a), 128'd3);
        check("s1_dv2_lat3", 2, 128'(dv_cnt[2][2] - s_b), 128'd3);
        rq = '0;
        repeat (3) step();

        // All four requesting and reading every cycle
        rq = 4'hF; en = 4'hF;
        for (int i = 0; i < N; i++) set_addr(i, 16 * i + 1);
        base = en_own.size();
        repeat (48) step();
        rq = '0; en = '0;
        repeat (4) step();
        check("s2_nreads", 0, 128'(en_own.size() >= base + 33), 128'h1);
        if (en_own.size() >= base + 33) begin
            for (int j = 0; j < 33; j++) check("s2_order", 0, 128'(en_own[base+j]), 128'(order[j/8]));
            for (int b = 1; b <= 4; b++)
                check("s2_gap", 0, 128'(en_cyc[base+8*b] - en_cyc[base+8*b-1]), 128'd3);
            check("s2_burst_span", 0, 128'(en_cyc[base+7] - en_cyc[base]), 128'd7);
        end

        // GBFWEI busy for three cycles mid-burst; burst still totals MAX_BURST
        rq = 4'b0001; en = 4'b0001; set_addr(0, 'h100);
        base = en_own.size();
        repeat (4) step();
        gb = 1'b1;
        repeat (3) begin
            neg();
            check("s3_busy_owner", 0, 128'(o_busy[0][0]), 128'h1);
            check("s3_no_en", 0, 128'(o_en[0]), 128'h0);
            pos();
        end
        gb = 1'b0;
        repeat (5) step();
        rq = '0; en = '0;
        repeat (3) step();
        check("s3_burst_total", 0, 128'(en_own.size() - base), 128'd8);

        // Non-owner 1 strobes EnRd at 0x3FF while requester 0 owns
        rq = 4'b0001; en = '0;
        step();
        en = 4'b0010; set_addr(1, 'h3FF); s_a = dv_cnt[0][1]; base = en_own.size();
        repeat (3) begin
            neg();
            check("s4_no_en", 0, 128'(o_en[0]), 128'h0);
            check("s4_busy", 0, 128'(o_busy[0]), 128'b1110);
            pos();
        end
        en = '0;
        repeat (3) step();
        check("s4_dv1", 0, 128'(dv_cnt[0][1] - s_a), 128'd0);
        check("s4_nreads", 0, 128'(en_own.size() - base), 128'd0);
        rq = '0;
        repeat (3) step();

        // Requester 3 reads twice and drops; 0 granted next; returns go to 3 only
        rq = 4'b1001; en = '0; set_addr(3, 'h2A0);
        s_a = dv_cnt[2][3]; s_b = dv_cnt[2][0]; s_c = dv_cnt[0][0];
        step();
        en = 4'b1000;
        step(); step();
        rq = 4'b0001; en = '0;
        step(); step(); step();
        neg(); check("s5_grant0", 0, 128'(o_busy[0]), 128'b1110); pos();
        step();
        check("s5_dv3_lat3", 2, 128'(dv_cnt[2][3] - s_a), 128'd2);
        check("s5_dv0_lat3", 2, 128'(dv_cnt[2][0] - s_b), 128'd0);
        check("s5_dv0_lat1", 0, 128'(dv_cnt[0][0] - s_c), 128'd0);

        // Flush one cycle after a read: no return at latency 2 or 3, pointer back to 0
        rq = 4'b0011; en = 4'b0001; set_addr(0, 'h055);
        s_a = dv_cnt[1][0]; s_b = dv_cnt[2][0];
        neg(); check("s6_read", 0, 128'(o_en[0]), 128'h1); pos();
        en = '0; fl = 1'b1;
        step();
        fl = 1'b0;
        neg();
`ifdef GBFWEI_ARB_PERF_EN
        check("s6_stall_clr", 0, 128'(o_stall[0]), 128'h0);
`endif
        check("s6_release_busy", 0, 128'(o_busy[0]), 128'hF);
        pos();
        step();
        neg(); check("s6_rrptr0", 0, 128'(o_busy[0]), 128'b1110); pos();
        step(); step();
        check("s6_dv_lat2", 1, 128'(dv_cnt[1][0] - s_a), 128'd0);
        check("s6_dv_lat3", 2, 128'(dv_cnt[2][0] - s_b), 128'd0);
        rq = '0;
        repeat (3) step();

        // Randomized traffic against the model
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0) rq = rq ^ (4'b0001 << $urandom_range(0, 3));
            en = ($urandom_range(0, 3) != 0) ? (rq & 4'($urandom)) | rq : 4'($urandom);
            for (int i = 0; i < N; i++) set_addr(i, int'($urandom_range(0, 4095)));
            gb = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 63) == 0);
            gdat = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
                step(); step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gbfwei_rd_arb.md
Name: gbfwei_rd_arb

Overview:
- Round-robin arbiter that shares one weight global-buffer read port (GBFWEI) among NUM_REQ weight distributors, one per PE column group.
- Grants burst ownership to one requester at a time and forwards that requester's read enable and address.
- Routes the returning read data and a per-requester valid strobe back to the issuing requester.
- Sits between the distributor instances and the GBFWEI SRAM wrapper. Frame-finish flushes it.

Parameters:
- NUM_REQ, 4, number of distributor requesters (2..8)
- ADDR_WIDTH, 12, GBFWEI read address width
- PORT_WIDTH, 96, GBFWEI read data width
- RD_LATENCY, 1, cycles from GBFWEI_EnRd to GBFWEI_DatRd valid (1..4)
- MAX_BURST, 8, maximum reads per ownership before a forced rotation (power of 2, ≥2)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- CTRLACT_FnhFrm  in  1  frame finish; synchronous flush
- Req_Rqst  in  NUM_REQ  level; requester i wants the port
- Req_EnRd  in  NUM_REQ  read strobe per requester
- Req_AddrRd  in  NUM_REQ*ADDR_WIDTH  read address per requester; requester i uses slice i
- Req_BusyRd  out  NUM_REQ  1 = requester i must not assert EnRd
- Req_DatVal  out  NUM_REQ  1-cycle strobe; Req_DatRd belongs to requester i
- Req_DatRd  out  PORT_WIDTH  returned data, broadcast to all requesters
- GBFWEI_EnRd  out  1  read enable to GBFWEI
- GBFWEI_AddrRd  out  ADDR_WIDTH  read address to GBFWEI
- GBFWEI_BusyRd  in  1  GBFWEI cannot accept a read this cycle
- GBFWEI_DatRd  in  PORT_WIDTH  read data from GBFWEI

Behaviour:
- Registered state: FSM {IDLE, OWN, RELEASE}, Owner (log2 NUM_REQ bits), RrPtr, BurstCnt, and an id/valid shift pipe RD_LATENCY deep.
- Reset values: state=IDLE, Owner=0, RrPtr=0, BurstCnt=0, pipe valid=0.
- Outputs at reset: Req_BusyRd all 1, Req_DatVal=0, GBFWEI_EnRd=0, GBFWEI_AddrRd=0, Req_DatRd=GBFWEI_DatRd (pass-through).

FSM transitions:
- IDLE: if any Req_Rqst is set, pick the first set bit at or after RrPtr (circular). Load Owner, clear BurstCnt, go to OWN next cycle. Arbitration itself costs 1 cycle.
- OWN → RELEASE when any of these holds:
  - Req_Rqst[Owner] drops, or
  - an accepted read brings BurstCnt to MAX_BURST, or
  - CTRLACT_FnhFrm is asserted.
- RELEASE: RrPtr <= Owner+1 (wrap to 0 after NUM_REQ-1). Go to IDLE. This is a one-cycle bubble.

Grant and forwarding:
- Req_BusyRd[i] = !(state==OWN && Owner==i) || GBFWEI_BusyRd. Combinational from registers and GBFWEI_BusyRd only; never depends on Req_EnRd, so there is no loop.
- Accepted read = state==OWN && Req_EnRd[Owner] && !GBFWEI_BusyRd.
- GBFWEI_EnRd = accepted read. GBFWEI_AddrRd = Req_AddrRd slice of Owner; the mux output is 0 when not in OWN.
- Req_EnRd from a non-owner, or any EnRd while GBFWEI_BusyRd=1, is ignored: no read is issued and no valid is produced.
- BurstCnt increments per accepted read. It is log2(MAX_BURST)+1 bits and saturates at MAX_BURST.
- The read that reaches MAX_BURST is still issued; the read limit is exact.

Data return:
- Each accepted read pushes {valid=1, Owner} into the pipe. After RD_LATENCY cycles, Req_DatVal[id]=1 for exactly 1 cycle.
- Return is independent of ownership changes: data issued before RELEASE is still delivered to its issuer.

Flush (CTRLACT_FnhFrm=1):
- Clears all pipe valids in that cycle, so no Req_DatVal is produced for in-flight reads.
- Sets RrPtr=0 and forces state to RELEASE then IDLE, or keeps IDLE.
- A Req_EnRd in the same cycle as the flush is not issued.

Other rules:
- Simultaneous release and new request: no grant in the RELEASE cycle. The new owner is picked in IDLE on the following cycle.
- Single requester holding Rqst continuously: bursts of MAX_BURST reads separated by 2 idle cycles (RELEASE + IDLE).
- Reset mid-operation: async clear of all state. In-flight data is discarded.

Optional Feature:
- Macro GBFWEI_ARB_PERF_EN adds output ArbStallCnt [31:0].
- The counter increments each cycle in which some i has Req_Rqst[i]=1 and Req_BusyRd[i]=1.
- It saturates at 32'hFFFF_FFFF, clears on reset and on CTRLACT_FnhFrm, and its output is registered.
- Without the macro the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Single requester 2, Rqst held, 3 reads at addrs 0x010..0x012 then Rqst drops → Owner=2 one cycle after Rqst. GBFWEI_AddrRd shows 0x010, 0x011, 0x012. Req_DatVal[2] pulses 3 times at RD_LATENCY=1. RrPtr=3 after RELEASE.
- All 4 requesters request continuously, each reading every cycle, MAX_BURST=8 → grant order 0,1,2,3,0. Exactly 8 GBFWEI_EnRd per ownership. 2-cycle gap between bursts.
- GBFWEI_BusyRd high 3 cycles mid-burst → Req_BusyRd[Owner]=1, no GBFWEI_EnRd in those cycles, BurstCnt unchanged. Burst resumes and still totals 8.
- Non-owner 1 pulses Req_EnRd with addr 0x3FF while requester 0 owns the port → no read to 0x3FF issued, Req_DatVal[1] stays 0.
- RD_LATENCY=3, requester 3 issues 2 reads then drops Rqst, and requester 0 is granted immediately after → both returns strobe Req_DatVal[3], never Req_DatVal[0].
- CTRLACT_FnhFrm asserted 1 cycle after a read with RD_LATENCY=2 → no Req_DatVal for that read. State returns to IDLE, RrPtr=0. With GBFWEI_ARB_PERF_EN, ArbStallCnt reads 0 on the next cycle.
